instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit for the 16-bit processor. It is the reader side of the combinational program memory. It drives the program-memory address, samples the returned word, and bundles the 4-bit-opcode instruction with its immediate data word when the opcode takes one. It then hands the bundle to the decode/execute stage over a valid/ready handshake, and takes PC redirects for taken branches.

## Interface
- ADDR_W, 5, program-memory address width; the PC wraps modulo 2^ADDR_W
- INSTR_W, 16, instruction/data word width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- fetch_en  in  1  level; allows fetching to start or continue
- pm_addr  out  ADDR_W  program-memory address; combinationally equal to the PC
- pm_instr  in  INSTR_W  program-memory word, valid in the same cycle as pm_addr
- out_valid  out  1  bundle available
- out_ready  in  1  consumer accepts the bundle
- out_instr  out  INSTR_W  opcode word
- out_imm  out  INSTR_W  immediate word; 0 when out_has_imm=0
- out_has_imm  out  1  bundle is a two-word instruction
- out_pc  out  ADDR_W  address of the opcode word
- redirect_valid  in  1  one-cycle PC override (taken branch/jump)
- redirect_addr  in  ADDR_W  new PC

## Operation
- Opcode is instr[15:12].
- Two-word opcodes, which carry a following data word: 0000 (load imm), 0100 (xor imm), 0110 (addi), 0111 (cmp imm), 1001 (subi).
- All other opcodes are one word.
- Jump target field is instr[11:7].
- States: IDLE, OP, IMM, OUT.
  - IDLE: out_valid=0. Go to OP when fetch_en=1.
  - OP: latch pm_instr into out_instr and the PC into out_pc; PC<=PC+1. If the opcode is two-word, go to IMM. Otherwise set out_imm<=0 and out_has_imm<=0, then go to OUT.
  - IMM: latch pm_instr into out_imm, set out_has_imm<=1, PC<=PC+1, go to OUT.
  - OUT: out_valid=1; registers hold stable. On out_valid&&out_ready, go to OP if fetch_en=1, else go to IDLE.
- Redirect takes priority in every state:
  - PC<=redirect_addr, next state OP (IDLE if fetch_en=0), out_valid=0 next cycle.
  - A partially assembled bundle (state IMM) is discarded.
  - If the redirect coincides with an OUT handshake, the bundle counts as consumed and the redirect still wins for the PC.
- PC arithmetic: ADDR_W-bit unsigned, so 31+1=0. An opcode at 31 takes its immediate from address 0.
- fetch_en dropping mid-instruction: the current bundle completes; the unit goes idle only after the handshake.
- The data word is never opcode-decoded. An immediate of 0x0000 or 0xFFFF is passed through unchanged.

## Timing
- Reset values:
  - PC=0, state IDLE.
  - out_valid=0, out_instr=0, out_imm=0, out_has_imm=0, out_pc=0.
  - pm_addr=0.
- Reset is asynchronous at any state, including mid-IMM; the partial bundle is lost.
- Latency, measured from the OP cycle: out_valid rises 1 cycle later for one-word opcodes and 2 cycles later for two-word opcodes.
- Throughput with out_ready held high: one-word instruction every 2 cycles; two-word every 3.
- out_* are stable while out_valid=1 and out_ready=0.
- A redirect sampled at edge N: pm_addr=redirect_addr in cycle N+1, and the first new bundle is valid at N+2 or later.

## Configuration
- FETCH_JUMP_FOLD_EN
  - Defined: opcode 0101 seen in OP is resolved inside the unit. PC<=instr[11:7], state stays OP, no bundle is emitted, and the jump costs 1 cycle.
  - Undefined: 0101 is emitted as an ordinary one-word bundle, and the consumer must issue a redirect.
- Redirect still has priority over a folded jump in the same cycle.

## Structure
- Shared package fetch_pkg holds:
  - opcode localparams (OP_LOAD_IMM=4'b0000, OP_XOR_IMM=4'b0100, OP_JMP=4'b0101, OP_ADDI=4'b0110, OP_CMP_IMM=4'b0111, OP_BR=4'b1000, OP_SUBI=4'b1001, …)
  - the state enum
  - function is_two_word(opcode)
- One sub-module is natural: instr_len_decode, a combinational block taking opcode and returning two_word and is_jump. Execute reuses it.

## Test plan
- Program word 0=0x0000, word 1=0x0006, out_ready=1, fetch_en rises -> first bundle out_instr=0x0000, out_imm=0x0006, out_has_imm=1, out_pc=0. Next pm_addr=2.
- Word 2=0xA002 (LSL, one word), out_ready held 0 for 5 cycles -> out_valid stays 1 with out_instr=0xA002, out_imm=0, out_pc=2, all stable; the next bundle has out_pc=3 after ready.
- Bundle at pc 23 (0x8A00) accepted, then redirect_valid=1 with redirect_addr=20 in the same cycle -> next pm_addr=20, next bundle out_pc=20.
- FETCH_JUMP_FOLD_EN defined, word 28=0x5000 -> no bundle with out_pc=28; the next bundle has out_pc=0. Undefined -> a bundle with out_instr=0x5000 and out_pc=28 is emitted.
- rst_n low during IMM of the pc 4/5 subi -> outputs return to reset values immediately; after release the first bundle has out_pc=0.
- redirect_addr=31 with word 31=0x6300 (addi) and word 0=0x0001 -> out_imm=0x0001, out_pc=31; next pm_addr=1.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: opcode encodings, fetch FSM states and instruction-length helper
package fetch_pkg;

    localparam logic [3:0] OP_LOAD_IMM = 4'b0000;
    localparam logic [3:0] OP_XOR_IMM  = 4'b0100;
    localparam logic [3:0] OP_JMP      = 4'b0101;
    localparam logic [3:0] OP_ADDI     = 4'b0110;
    localparam logic [3:0] OP_CMP_IMM  = 4'b0111;
    localparam logic [3:0] OP_BR       = 4'b1000;
    localparam logic [3:0] OP_SUBI     = 4'b1001;
    localparam logic [3:0] OP_LSL      = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OP,
        ST_IMM,
        ST_OUT
    } fetch_state_t;

    // Opcodes followed by an immediate data word in program memory
    function automatic logic is_two_word(input logic [3:0] opcode);
        return (opcode == OP_LOAD_IMM) || (opcode == OP_XOR_IMM) || (opcode == OP_ADDI) ||
               (opcode == OP_CMP_IMM) || (opcode == OP_SUBI);
    endfunction

endpackage

// File: rtl/instr_len_decode.sv
// instr_len_decode: classifies an opcode as two-word and/or jump
module instr_len_decode
    import fetch_pkg::*;
(
    input  logic [3:0] i_opcode,
    output logic       o_two_word,
    output logic       o_is_jump
);

    // Pure opcode classification, shared with the execute stage
    always_comb begin
        o_two_word = is_two_word(i_opcode);
        o_is_jump  = (i_opcode == OP_JMP);
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: program-memory reader assembling opcode+immediate bundles; FETCH_JUMP_FOLD_EN folds jumps
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_en,
    output logic [ADDR_W-1:0]  pm_addr,
    input  logic [INSTR_W-1:0] pm_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [INSTR_W-1:0] out_imm,
    output logic               out_has_imm,
    output logic [ADDR_W-1:0]  out_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr
);

`ifdef FETCH_JUMP_FOLD_EN
    localparam bit FOLD = 1'b1;
`else
    localparam bit FOLD = 1'b0;
`endif

    fetch_state_t       r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [INSTR_W-1:0] r_imm;
    logic               r_has_imm;
    logic [ADDR_W-1:0]  r_out_pc;
    logic               w_two_word;
    logic               w_is_jump;
    logic [ADDR_W-1:0]  w_jump_target;

    instr_len_decode u_len (
        .i_opcode   (pm_instr[INSTR_W-1 -: 4]),
        .o_two_word (w_two_word),
        .o_is_jump  (w_is_jump)
    );

    assign w_jump_target = ADDR_W'(pm_instr[11:7]);
    assign pm_addr       = r_pc;
    assign out_valid     = r_valid;
    assign out_instr     = r_instr;
    assign out_imm       = r_imm;
    assign out_has_imm   = r_has_imm;
    assign out_pc        = r_out_pc;

    // Fetch FSM: redirect overrides everything, otherwise walk OP -> (IMM) -> OUT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_valid   <= 1'b0;
            r_instr   <= '0;
            r_imm     <= '0;
            r_has_imm <= 1'b0;
            r_out_pc  <= '0;
        end else if (redirect_valid) begin
            r_pc    <= redirect_addr;
            r_state <= fetch_en ? ST_OP : ST_IDLE;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (fetch_en) r_state <= ST_OP;
                ST_OP: begin
                    if (FOLD && w_is_jump) begin
                        r_pc <= w_jump_target;
                    end else begin
                        r_instr  <= pm_instr;
                        r_out_pc <= r_pc;
                        r_pc     <= r_pc + ADDR_W'(1);
                        if (w_two_word) begin
                            r_state <= ST_IMM;
                        end else begin
                            r_imm     <= '0;
                            r_has_imm <= 1'b0;
                            r_valid   <= 1'b1;
                            r_state   <= ST_OUT;
                        end
                    end
                end
                ST_IMM: begin
                    r_imm     <= pm_instr;
                    r_has_imm <= 1'b1;
                    r_pc      <= r_pc + ADDR_W'(1);
                    r_valid   <= 1'b1;
                    r_state   <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_state <= fetch_en ? ST_OP : ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scoreboard bench for instr_fetch
module tb_instr_fetch;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] imm;
        logic        has;
        logic [4:0]  pc;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [4:0]  pm_addr;
    logic [15:0] pm_instr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_imm;
    logic        out_has_imm;
    logic [4:0]  out_pc;
    logic        redirect_valid;
    logic [4:0]  redirect_addr;

    logic [15:0] mem [32];
    bundle_t     q[$];
    int          errors = 0;
    int          checks = 0;

    instr_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .pm_addr        (pm_addr),
        .pm_instr       (pm_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_imm        (out_imm),
        .out_has_imm    (out_has_imm),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr)
    );

    assign pm_instr = mem[pm_addr];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] instr, input logic [15:0] imm, input logic has, input logic [4:0] pc);
        bundle_t b;
        b.instr = instr;
        b.imm   = imm;
        b.has   = has;
        b.pc    = pc;
        q.push_back(b);
    endtask

    task automatic wait_valid_pc(input logic [4:0] pc);
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (out_valid && out_pc == pc) break;
        end
        chk("wait_valid_pc", {out_valid, out_pc}, {1'b1, pc});
    endtask

    task automatic wait_addr(input logic [4:0] a);
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (pm_addr == a) break;
        end
        chk("wait_addr", pm_addr, a);
    endtask

    // Scoreboard: every accepted bundle must match the oldest expected one
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_bundle_pc", out_pc, 5'h1f ^ out_pc);
            end else begin
                bundle_t e;
                e = q.pop_front();
                chk("sb_instr", out_instr, e.instr);
                chk("sb_imm", out_imm, e.imm);
                chk("sb_has_imm", out_has_imm, e.has);
                chk("sb_pc", out_pc, e.pc);
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 16'hA000;
        mem[0]  = 16'h0000; mem[1]  = 16'h0006;
        mem[2]  = 16'hA002; mem[3]  = 16'h1234;
        mem[4]  = 16'h9100; mem[5]  = 16'hFFFF;
        mem[6]  = 16'h4000; mem[7]  = 16'h0000;
        mem[20] = 16'h7000; mem[21] = 16'h00AB;
        mem[23] = 16'h8A00; mem[28] = 16'h5000;
        mem[31] = 16'h6300;
        rst_n = 1'b0; fetch_en = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_addr = '0;
        #3;
        chk("rst_valid", out_valid, 0);
        chk("rst_pm_addr", pm_addr, 0);
        chk("rst_instr", out_instr, 0);
        chk("rst_imm", out_imm, 0);
        chk("rst_has_imm", out_has_imm, 0);
        chk("rst_pc", out_pc, 0);
        step(2);
        rst_n = 1'b1;
        push(16'h0000, 16'h0006, 1'b1, 5'd0);
        out_ready = 1'b1; fetch_en = 1'b1;
        wait_valid_pc(5'd0);
        chk("after_first_pm_addr", pm_addr, 2);
        step(1);
        out_ready = 1'b0;
        push(16'hA002, 16'h0000, 1'b0, 5'd2);
        wait_valid_pc(5'd2);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_instr", out_instr, 16'hA002);
            chk("hold_imm", out_imm, 0);
            chk("hold_has_imm", out_has_imm, 0);
            chk("hold_pc", out_pc, 2);
            step(1);
        end
        push(16'h1234, 16'h0000, 1'b0, 5'd3);
        out_ready = 1'b1;
        wait_valid_pc(5'd3);
        wait_addr(5'd5);
        rst_n = 1'b0;
        #1;
        chk("midimm_rst_valid", out_valid, 0);
        chk("midimm_rst_pm_addr", pm_addr, 0);
        chk("midimm_rst_instr", out_instr, 0);
        chk("midimm_rst_pc", out_pc, 0);
        chk("sb_empty_at_rst", q.size(), 0);
        fetch_en = 1'b0;
        step(2);
        rst_n = 1'b1;
        fetch_en = 1'b1;
        push(16'h0000, 16'h0006, 1'b1, 5'd0);
        push(16'hA002, 16'h0000, 1'b0, 5'd2);
        push(16'h1234, 16'h0000, 1'b0, 5'd3);
        push(16'h9100, 16'hFFFF, 1'b1, 5'd4);
        push(16'h4000, 16'h0000, 1'b1, 5'd6);
        wait_valid_pc(5'd6);
        fetch_en = 1'b0;
        step(3);
        chk("idle_valid", out_valid, 0);
        chk("idle_pm_addr", pm_addr, 8);
        redirect_valid = 1'b1; redirect_addr = 5'd23; fetch_en = 1'b1;
        step(1);
        redirect_valid = 1'b0;
        chk("redir_pm_addr_23", pm_addr, 23);
        push(16'h8A00, 16'h0000, 1'b0, 5'd23);
        wait_valid_pc(5'd23);
        redirect_valid = 1'b1; redirect_addr = 5'd20;
        step(1);
        redirect_valid = 1'b0;
        chk("redir_pm_addr_20", pm_addr, 20);
        chk("redir_valid_low", out_valid, 0);
        push(16'h7000, 16'h00AB, 1'b1, 5'd20);
        wait_valid_pc(5'd20);
        redirect_valid = 1'b1; redirect_addr = 5'd28;
        step(1);
        redirect_valid = 1'b0;
        chk("redir_pm_addr_28", pm_addr, 28);
`ifdef FETCH_JUMP_FOLD_EN
        push(16'h0000, 16'h0006, 1'b1, 5'd0);
        wait_valid_pc(5'd0);
`else
        push(16'h5000, 16'h0000, 1'b0, 5'd28);
        wait_valid_pc(5'd28);
`endif
        mem[0] = 16'h0001;
        redirect_valid = 1'b1; redirect_addr = 5'd31;
        step(1);
        redirect_valid = 1'b0;
        chk("redir_pm_addr_31", pm_addr, 31);
        push(16'h6300, 16'h0001, 1'b1, 5'd31);
        wait_valid_pc(5'd31);
        chk("wrap_pm_addr", pm_addr, 1);
        fetch_en = 1'b0;
        step(3);
        chk("final_valid", out_valid, 0);
        chk("sb_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
